// File: rtl/hex_display_driver.sv
// rtl/hex_display_driver.sv - four-digit multiplexed hex display driver with frame-synchronous value update
module hex_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Value,
  input  logic        Load,
  input  logic        Blank,
  output logic [6:0]  Segments,
  output logic [3:0]  Anodes,
  output logic        FrameDone
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    digitIdx;
  logic [15:0]   shown;
  logic [15:0]   pending;
  logic          pendingValid;

  logic          tick;
  logic          frameBoundary;
  logic [3:0]    nibble;
  logic [6:0]    segCode;
  logic          leadingZero;
  logic          digitDark;

  assign tick          = (prescaler == PRE_MAX);
  assign frameBoundary = tick && (digitIdx == 2'd3);

  // Prescaler and digit scan; each digit stays lit for REFRESH_DIV cycles
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prescaler <= '0;
      digitIdx  <= 2'd0;
    end else begin
      if (tick) begin
        prescaler <= '0;
        digitIdx  <= digitIdx + 2'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  // Double-buffered value: Load fills pending, the frame boundary commits it so a frame never tears
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shown        <= '0;
      pending      <= '0;
      pendingValid <= 1'b0;
    end else begin
      if (frameBoundary) begin
        // A Load on the boundary itself is newer than anything pending, so it wins outright
        if (Load) begin
          shown        <= Value;
          pendingValid <= 1'b0;
        end else if (pendingValid) begin
          shown        <= pending;
          pendingValid <= 1'b0;
        end
      end else if (Load) begin
        pending      <= Value;
        pendingValid <= 1'b1;
      end
    end
  end

  // Nibble select for the digit currently being scanned
  always_comb begin
    nibble = 4'h0;
    case (digitIdx)
      2'd0: nibble = shown[3:0];
      2'd1: nibble = shown[7:4];
      2'd2: nibble = shown[11:8];
      2'd3: nibble = shown[15:12];
      default: nibble = 4'h0;
    endcase
  end

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}
  always_comb begin
    segCode = 7'b1111111;
    case (nibble)
      4'h0: segCode = 7'b1000000;
      4'h1: segCode = 7'b1111001;
      4'h2: segCode = 7'b0100100;
      4'h3: segCode = 7'b0110000;
      4'h4: segCode = 7'b0011001;
      4'h5: segCode = 7'b0010010;
      4'h6: segCode = 7'b0000010;
      4'h7: segCode = 7'b1111000;
      4'h8: segCode = 7'b0000000;
      4'h9: segCode = 7'b0010000;
      4'hA: segCode = 7'b0001000;
      4'hB: segCode = 7'b0000011;
      4'hC: segCode = 7'b1000110;
      4'hD: segCode = 7'b0100001;
      4'hE: segCode = 7'b0000110;
      4'hF: segCode = 7'b0001110;
      default: segCode = 7'b1111111;
    endcase
  end

  // Leading-zero detect: a digit is dark when it and every more-significant nibble are zero; digit 0 always shows
  always_comb begin
    leadingZero = 1'b0;
    case (digitIdx)
      2'd0: leadingZero = 1'b0;
      2'd1: leadingZero = (shown[15:4] == 12'h000);
      2'd2: leadingZero = (shown[15:8] == 8'h00);
      2'd3: leadingZero = (shown[15:12] == 4'h0);
      default: leadingZero = 1'b0;
    endcase
    digitDark = Blank || (LZ_BLANK && leadingZero);
  end

  // Registered display outputs and frame pulse
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Segments  <= 7'b1111111;
      Anodes    <= 4'b1111;
      FrameDone <= 1'b0;
    end else begin
      FrameDone <= frameBoundary;
      if (digitDark) begin
        Segments <= 7'b1111111;
        Anodes   <= 4'b1111;
      end else begin
        Segments <= segCode;
        Anodes   <= ~(4'b0001 << digitIdx);
      end
    end
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// tb/tb_hex_display_driver.sv - self-checking bench for hex_display_driver
module tb_hex_display_driver;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Value = 16'h0000;
  logic        Load  = 1'b0;
  logic        Blank = 1'b0;
  logic [6:0]  Segments;
  logic [3:0]  Anodes;
  logic        FrameDone;

  always #5 Clock = ~Clock;

  hex_display_driver #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Value(Value), .Load(Load), .Blank(Blank),
    .Segments(Segments), .Anodes(Anodes), .FrameDone(FrameDone)
  );

  localparam logic [6:0] DARK = 7'b1111111;
  logic [6:0] hexGlyph [16];

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
  } exp_t;
  exp_t sbQueue [$];

  typedef struct {
    logic        hasPre;
    logic [15:0] pre;
    logic [15:0] value;
    logic [27:0] expSegs;
  } vec_t;
  vec_t vecs [5];

  int nChecks = 0;
  int nFails  = 0;

  int          mPre, mIdx;
  logic [15:0] mShown, mPend;
  logic        mPv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mPre = 0; mIdx = 0; mShown = 16'h0; mPend = 16'h0; mPv = 1'b0;
  endtask

  // One clock: predict registered outputs, push, clock, pop and compare
  task automatic step();
    exp_t e;
    exp_t got;
    logic tick;
    if (!Reset) begin
      e = '{DARK, 4'hF, 1'b0};
      modelReset();
    end else begin
      tick = (mPre == 3);
      e.fd = tick && (mIdx == 3);
      if (Blank || (mIdx != 0 && (mShown >> (4 * mIdx)) == 16'h0)) begin
        e.seg = DARK;
        e.an  = 4'hF;
      end else begin
        e.seg = hexGlyph[mShown[4*mIdx +: 4]];
        e.an  = ~(4'b0001 << mIdx);
      end
      if (tick && mIdx == 3) begin
        if (Load) begin
          mShown = Value; mPv = 1'b0;
        end else if (mPv) begin
          mShown = mPend; mPv = 1'b0;
        end
      end else if (Load) begin
        mPend = Value; mPv = 1'b1;
      end
      mPre = tick ? 0 : mPre + 1;
      if (tick) mIdx = (mIdx + 1) % 4;
    end
    sbQueue.push_back(e);
    @(posedge Clock);
    #1;
    got = sbQueue.pop_front();
    check("scoreboard", {20'h0, Segments, Anodes, FrameDone}, {20'h0, got});
  endtask

  task automatic waitFrame();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      seen = FrameDone;
    end
    if (!seen) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic collectFrame(output logic [27:0] segs);
    segs = {4{DARK}};
    for (int k = 0; k < 16; k++) begin
      step();
      case (Anodes)
        4'b1110: segs[6:0]   = Segments;
        4'b1101: segs[13:7]  = Segments;
        4'b1011: segs[20:14] = Segments;
        4'b0111: segs[27:21] = Segments;
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [27:0] frame;
    int          period;
    logic        seen;

    hexGlyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // {hasPre, pre, value, digit3..digit0 glyphs}
    vecs[0] = '{1'b0, 16'h0000, 16'hA5F0, {7'b0001000, 7'b0010010, 7'b0001110, 7'b1000000}};
    vecs[1] = '{1'b1, 16'h1234, 16'h00C7, {DARK, DARK, 7'b1000110, 7'b1111000}};
    vecs[2] = '{1'b0, 16'h0000, 16'h0100, {DARK, 7'b1111001, 7'b1000000, 7'b1000000}};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, {DARK, DARK, DARK, 7'b1000000}};
    vecs[4] = '{1'b0, 16'h0000, 16'h3B6E, {7'b0110000, 7'b0000011, 7'b0000010, 7'b0000110}};

    modelReset();

    // Asynchronous reset before any clock edge
    #2 Reset = 1'b0;
    #1;
    check("reset_segments", {25'h0, Segments}, {25'h0, DARK});
    check("reset_anodes", {28'h0, Anodes}, 32'hF);
    check("reset_framedone", {31'h0, FrameDone}, 32'h0);
    step();
    step();
    Reset = 1'b1;
    step();
    check("release_anodes", {28'h0, Anodes}, 32'hE);
    check("release_segments", {25'h0, Segments}, {25'h0, 7'b1000000});

    // Frame period
    waitFrame();
    period = 0;
    seen   = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      period++;
      seen = FrameDone;
    end
    check("frame_period", period, 32'd16);

    // Table-driven value updates
    for (int v = 0; v < 5; v++) begin
      waitFrame();
      if (vecs[v].hasPre) begin
        Load = 1'b1; Value = vecs[v].pre;
        step();
        Load = 1'b0;
        step();
      end
      Load = 1'b1; Value = vecs[v].value;
      step();
      Load = 1'b0; Value = 16'h0;
      waitFrame();
      collectFrame(frame);
      check($sformatf("vec%0d_frame", v), {4'h0, frame}, {4'h0, vecs[v].expSegs});
    end

    // Load on the exact boundary cycle overrides an older pending value
    waitFrame();
    Load = 1'b1; Value = 16'h1111;
    step();
    Load = 1'b0;
    for (int k = 0; k < 20 && !(mPre == 3 && mIdx == 3); k++) step();
    Load = 1'b1; Value = 16'h8888;
    step();
    Load = 1'b0; Value = 16'h0;
    check("boundary_framedone", {31'h0, FrameDone}, 32'h1);
    collectFrame(frame);
    check("boundary_load_frame", {4'h0, frame}, {4'h0, {4{7'b0000000}}});
    waitFrame();
    collectFrame(frame);
    check("boundary_no_stale_pending", {4'h0, frame}, {4'h0, {4{7'b0000000}}});

    // Blank forces dark from the next cycle, scan keeps running
    step();
    Blank = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("blank_anodes", {28'h0, Anodes}, 32'hF);
    end
    Blank = 1'b0;
    for (int k = 0; k < 20; k++) step();

    // Mid-frame reset with FFFF pending
    waitFrame();
    Load = 1'b1; Value = 16'hFFFF;
    step();
    Load = 1'b0; Value = 16'h0;
    step();
    step();
    #2 Reset = 1'b0;
    #1;
    check("midreset_segments", {25'h0, Segments}, {25'h0, DARK});
    check("midreset_anodes", {28'h0, Anodes}, 32'hF);
    check("midreset_framedone", {31'h0, FrameDone}, 32'h0);
    modelReset();
    step();
    step();
    Reset = 1'b1;
    step();
    check("midreset_release_anodes", {28'h0, Anodes}, 32'hE);
    waitFrame();
    collectFrame(frame);
    check("midreset_frame", {4'h0, frame}, {4'h0, {DARK, DARK, DARK, 7'b1000000}});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/hex_display_driver.md
HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is lit (minimum 2).
REQ-002 SHALL have parameter LZ_BLANK, default 1, where 1 enables leading-zero blanking.
REQ-003 SHALL have port Clock, input, 1, the single system clock; all state changes on rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Value, input, 16, hex word to display (e.g. the Fibonacci Output bus).
REQ-006 SHALL have port Load, input, 1, capture strobe for Value, sampled each cycle.
REQ-007 SHALL have port Blank, input, 1, forces all digits dark while 1.
REQ-008 SHALL have port Segments, output, 7, active-low {g,f,e,d,c,b,a}.
REQ-009 SHALL have port Anodes, output, 4, active-low one-hot digit enable; bit 0 is the least-significant digit.
REQ-010 SHALL have port FrameDone, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-011 SHALL run prescaler 0..REFRESH_DIV-1, wrapping to 0; tick = prescaler at REFRESH_DIV-1.
REQ-012 SHALL advance digit index 0->1->2->3->0 on each tick and hold otherwise.
REQ-013 SHALL define the frame boundary as a tick while digit index = 3.
REQ-014 SHALL load Pending <= Value and set PendingValid on a cycle with Load=1 and no frame boundary; a later Load before the boundary overwrites Pending.
REQ-015 SHALL copy Shown <= Pending and clear PendingValid at a frame boundary when PendingValid=1; otherwise Shown is held.
REQ-016 SHALL, when Load=1 coincides with a frame boundary, write Value directly to Shown and leave PendingValid cleared, discarding any older Pending.
REQ-017 SHALL select nibble Shown[4i+3:4i] for digit index i.
REQ-018 SHALL encode the nibble as hex, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 SHALL, with LZ_BLANK=1, blank digit i (1..3) when that nibble and all more-significant nibbles of Shown are zero; digit 0 is never blanked by this rule.
REQ-020 SHALL drive a blanked digit as Anodes=4'b1111 and Segments=7'b1111111.
REQ-021 SHALL drive Anodes with bit i low, others high, for an unblanked digit i.
REQ-022 SHALL register Segments, Anodes and FrameDone; they reflect the digit index and Shown state one cycle after the edge that changes them.
REQ-023 SHALL pulse FrameDone high for exactly one cycle, one cycle after each frame boundary.
REQ-024 SHALL apply Blank combinationally into the output registers, so outputs go dark one cycle after Blank rises; the scan and load logic keep running.

Reset
REQ-025 SHALL, while Reset=0, force prescaler=0, digit index=0, Shown=0, Pending=0, PendingValid=0, Segments=7'b1111111, Anodes=4'b1111, FrameDone=0, independent of Clock.
REQ-026 SHALL, one cycle after Reset rises, show digit 0 of Shown=0 (Anodes=1110, Segments=1000000).
REQ-027 SHALL abandon the current frame and any pending value when Reset is asserted mid-frame; nothing is committed.

Verification (REFRESH_DIV=4, LZ_BLANK=1)
REQ-028 SHALL cover: reset release with no Load -> digit 0 lit "0" for 4 cycles; digits 1-3 dark; FrameDone every 16 cycles.
REQ-029 SHALL cover: Load Value=16'hA5F0 mid-frame -> outputs unchanged until the boundary; next frame shows 0,F,5,A on digits 0..3.
REQ-030 SHALL cover: Load 16'h1234 then Load 16'h00C7 in the same frame -> next frame shows 7,C on digits 0..1, digits 2-3 dark; 1234 is never displayed.
REQ-031 SHALL cover: Load 16'h8888 on the exact boundary cycle, with 16'h1111 pending -> next frame shows 8888; PendingValid=0 afterwards.
REQ-032 SHALL cover: Blank=1 for 10 cycles -> Anodes=1111 from the next cycle; scan resumes on the correct digit index when Blank drops.
REQ-033 SHALL cover: Reset pulsed low mid-frame with pending 16'hFFFF -> outputs dark immediately; after release shows "0", and FFFF is never displayed.
